// File: rtl/filter_pkg.sv
// Shared types and defaults for the sample-rate FIR scheduler and its helpers.
package filter_pkg;

    localparam int DEF_SAMPLE_W = 12;
    localparam int DEF_TAPS     = 16;
    localparam int DEF_COEF_W   = 8;
    localparam int DEF_SHIFT    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_MAC   = 3'd2,
        ST_SCALE = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    // Accumulator wide enough that a full sum of TAPS products never overflows.
    function automatic int acc_w(input int sample_w, input int coef_w, input int taps);
        return sample_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/sample_strobe_sync.sv
// Brings an asynchronous strobe into the clk domain and emits a one-cycle pulse per rising edge.
module sample_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic [2:0] sync_r;

    // Two synchronizer stages plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], async_in};
        end
    end

    assign edge_pulse = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/conv_filter_scheduler.sv
// FIR filter over a circular sample history, sharing one multiply-accumulate unit tap by tap.
module conv_filter_scheduler
    import filter_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int TAPS     = DEF_TAPS,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int SHIFT    = DEF_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_W-1:0]     inSample,
    input  logic                    inSampleReady,
    input  logic                    coefWe,
    input  logic [$clog2(TAPS)-1:0] coefAddr,
    input  logic [COEF_W-1:0]       coefData,
    input  logic                    overrunClr,
    output logic [SAMPLE_W-1:0]     outSample,
    output logic                    outValid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int PTR_W  = $clog2(TAPS);
    localparam int ACC_W  = acc_w(SAMPLE_W, COEF_W, TAPS);
    localparam int PROD_W = SAMPLE_W + COEF_W;
    localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(TAPS - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << SAMPLE_W) - 1);

    state_e              state_r, next_s;
    logic                edge_s;
    logic [SAMPLE_W-1:0] hist_r [TAPS];
    logic [COEF_W-1:0]   coef_r [TAPS];
    logic [PTR_W-1:0]    wr_ptr_r, k_r, rd_idx_s;
    logic [ACC_W-1:0]    acc_r, scaled_s;
    logic [PROD_W-1:0]   prod_s;
    logic [SAMPLE_W-1:0] sample_r, pend_r, sat_s, out_sample_r;
    logic                pending_r, overrun_r, out_valid_r, ovr_set_s;

    sample_strobe_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (inSampleReady),
        .edge_pulse (edge_s)
    );

    assign rd_idx_s  = wr_ptr_r - k_r;
    assign prod_s    = {{COEF_W{1'b0}}, hist_r[rd_idx_s]} * {{SAMPLE_W{1'b0}}, coef_r[k_r]};
    assign scaled_s  = acc_r >> SHIFT;
    assign sat_s     = (scaled_s > SAT_MAX) ? {SAMPLE_W{1'b1}} : scaled_s[SAMPLE_W-1:0];
    // OUT hands its freed slot straight to a simultaneous edge, so only MAC-side edges can overrun.
    assign ovr_set_s = edge_s && pending_r && (state_r != ST_IDLE) && (state_r != ST_OUT);

    assign outSample = out_sample_r;
    assign outValid  = out_valid_r;
    assign busy      = (state_r != ST_IDLE);
    assign overrun   = overrun_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state selection.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE:  next_s = edge_s ? ST_WRITE : ST_IDLE;
            ST_WRITE: next_s = ST_MAC;
            ST_MAC:   next_s = (k_r == LAST_TAP) ? ST_SCALE : ST_MAC;
            ST_SCALE: next_s = ST_OUT;
            ST_OUT:   next_s = (pending_r || edge_s) ? ST_WRITE : ST_IDLE;
            default:  next_s = ST_IDLE;
        endcase
    end

    // History, coefficient bank, MAC datapath and the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_r[i] <= '0;
                coef_r[i] <= COEF_W'(1);
            end
            wr_ptr_r     <= '0;
            k_r          <= '0;
            acc_r        <= '0;
            sample_r     <= '0;
            out_sample_r <= '0;
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) sample_r <= inSample;
                    if (coefWe) coef_r[coefAddr] <= coefData;
                end
                ST_WRITE: begin
                    hist_r[wr_ptr_r] <= sample_r;
                    acc_r            <= '0;
                    k_r              <= '0;
                end
                ST_MAC: begin
                    acc_r <= acc_r + {{(ACC_W - PROD_W){1'b0}}, prod_s};
                    if (k_r == LAST_TAP) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                    else                 k_r      <= k_r + PTR_W'(1);
                end
                ST_SCALE: begin
                    // Result is registered here so it is already stable during the OUT cycle.
                    out_sample_r <= sat_s;
                    out_valid_r  <= 1'b1;
                end
                ST_OUT: begin
                    if (pending_r)   sample_r <= pend_r;
                    else if (edge_s) sample_r <= inSample;
                end
                default: begin
                end
            endcase
        end
    end

    // One-deep pending slot and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r    <= '0;
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (state_r == ST_OUT) begin
                if (pending_r && edge_s) pend_r <= inSample;
                pending_r <= pending_r && edge_s;
            end else if (edge_s && (state_r != ST_IDLE) && !pending_r) begin
                pend_r    <= inSample;
                pending_r <= 1'b1;
            end
            if (ovr_set_s)       overrun_r <= 1'b1;
            else if (overrunClr) overrun_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Scoreboard bench: stimulus pushes expected results and arrival cycles; a monitor pops on outValid.
module tb_conv_filter_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] inSample;
    logic        inSampleReady;
    logic        coefWe;
    logic [3:0]  coefAddr;
    logic [7:0]  coefData;
    logic        overrunClr;
    logic [11:0] outSample;
    logic        outValid;
    logic        busy;
    logic        overrun;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    conv_filter_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inSample      (inSample),
        .inSampleReady (inSampleReady),
        .coefWe        (coefWe),
        .coefAddr      (coefAddr),
        .coefData      (coefData),
        .overrunClr    (overrunClr),
        .outSample     (outSample),
        .outValid      (outValid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every outValid pulse must match the oldest expectation in value and arrival cycle.
    always @(negedge clk) begin
        if (outValid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_out: got outSample=%0d at cycle %0d, required no output", outSample, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(outSample) != e.val) begin
                    errors = errors + 1;
                    $display("FAIL out_value: got %0d, required %0d", outSample, e.val);
                end
                checks = checks + 1;
                if (cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL out_latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int val, input int at);
        exp_t e;
        e.val = val;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Raises the strobe for two cycles; c is the cycle count at the rise.
    task automatic strobe(input int s, output int c);
        inSample      = 12'(s);
        inSampleReady = 1'b1;
        c             = cyc;
        idle(2);
        inSampleReady = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        coefWe   = 1'b1;
        coefAddr = 4'(addr);
        coefData = 8'(data);
        idle(1);
        coefWe   = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    int avg_exp [16] = '{6, 12, 18, 25, 31, 37, 43, 50, 56, 62, 68, 75, 81, 87, 93, 100};

    initial begin
        int c, c2, t;
        rst_n = 1'b0; inSample = 12'd0; inSampleReady = 1'b0;
        coefWe = 1'b0; coefAddr = 4'd0; coefData = 8'd0; overrunClr = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(50);
        chk("reset_outSample", outSample, 0);
        chk("reset_outValid", outValid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overrun", overrun, 0);

        // Single full-scale sample with default moving-average coefficients.
        strobe(4095, c);
        push(255, c + 21);
        idle(30);

        // Reset during MAC aborts at once and emits nothing afterwards.
        strobe(4095, c);
        idle(6);
        chk("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outSample", outSample, 0);
        chk("abort_outValid", outValid, 0);
        chk("abort_busy", busy, 0);
        idle(2);
        rst_n = 1'b1;
        idle(40);
        chk("post_abort_busy", busy, 0);

        // Ramp of identical samples fills the history.
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            strobe(100, c);
            push(avg_exp[i], c + 21);
            idle(38);
        end
        strobe(0, c);
        push(93, c + 21);
        idle(38);

        // Coefficients written in IDLE take effect and saturate the result.
        reset_dut();
        for (int k = 0; k < 16; k++) write_coef(k, (k == 0) ? 255 : 0);
        strobe(4095, c);
        push(4095, c + 21);
        idle(30);

        // The same writes while busy are ignored.
        reset_dut();
        strobe(4095, c);
        push(255, c + 21);
        idle(2);
        chk("busy_during_writes", busy, 1);
        for (int k = 0; k < 16; k++) write_coef(k, (k == 0) ? 255 : 0);
        idle(30);

        // Three edges in one computation: second is queued, third overruns and is dropped.
        reset_dut();
        strobe(10, c);
        push(0, c + 21);
        idle(3);
        strobe(20, c2);
        push(1, c + 40);
        idle(3);
        strobe(30, c2);
        idle(40);
        chk("overrun_set", overrun, 1);
        chk("overrun_idle_busy", busy, 0);
        strobe(0, c);
        push(1, c + 21);
        idle(30);
        chk("overrun_sticky", overrun, 1);
        overrunClr = 1'b1;
        idle(1);
        overrunClr = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Edge landing in the OUT cycle while a sample is pending takes the freed slot.
        reset_dut();
        strobe(160, c);
        push(10, c + 21);
        idle(3);
        strobe(320, c2);
        push(30, c + 40);
        idle(12);
        strobe(480, c2);
        push(60, c + 59);
        idle(60);
        chk("out_edge_no_overrun", overrun, 0);

        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            idle(1);
            t++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
